// File: rtl/move_scheduler_if.sv
// Command handshake between move_scheduler (master) and the piece engine (slave).
// The master holds cmd_valid and cmd until the slave returns a one-cycle cmd_ack.
interface move_scheduler_if;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic       cmd_ack;

  modport master (output cmd_valid, output cmd, input cmd_ack);
  modport slave  (input cmd_valid, input cmd, output cmd_ack);
endinterface

// File: rtl/move_scheduler.sv
// move_scheduler: merges debounced/auto-repeated button presses and a
// level-scaled gravity tick into one piece-engine command at a time.
// Command codes: 0=LEFT 1=RIGHT 2=DOWN 3=ROTATE 4=GRAVITY. Pending bits are
// indexed by the same codes, so the acked command clears pend[cmd].
module move_scheduler #(
  parameter logic [23:0] TICK_DIV   = 24'd8_388_608,
  parameter logic [23:0] LVL_STEP   = 24'd524_288,
  parameter logic [23:0] MIN_PERIOD = 24'd1_048_576,
  parameter logic [19:0] DEB_CYCLES = 20'd1_000_000,
  parameter logic [23:0] RPT_CYCLES = 24'd10_000_000
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             game_over,
  input  logic             BtnL,
  input  logic             BtnR,
  input  logic             BtnD,
  input  logic             BtnU,
  input  logic [3:0]       level,
  move_scheduler_if.master cmd_if,
  output logic             running,
  output logic             grav_ovr
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ISSUE, S_OVER} state_t;

  localparam logic [19:0] DEB_LAST = DEB_CYCLES - 20'd1;
  localparam logic [23:0] RPT_LAST = RPT_CYCLES - 24'd1;

  // Highest-priority pending request: GRAVITY > ROTATE > LEFT > RIGHT > DOWN.
  function automatic logic [2:0] pick_cmd(input logic [4:0] p);
    if (p[4])      return 3'd4;
    else if (p[3]) return 3'd3;
    else if (p[0]) return 3'd0;
    else if (p[1]) return 3'd1;
    else           return 3'd2;
  endfunction

  // Gravity period clamped to the floor; 28-bit math so a large level never wraps.
  function automatic logic [23:0] grav_period(input logic [3:0] lvl);
    logic [27:0] prod;
    logic [27:0] diff;
    prod = 28'(lvl) * 28'(LVL_STEP);
    diff = (prod >= {4'd0, TICK_DIV}) ? 28'd0 : ({4'd0, TICK_DIV} - prod);
    if (diff < {4'd0, MIN_PERIOD}) return MIN_PERIOD;
    else                           return diff[23:0];
  endfunction

  state_t      state_q, state_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [2:0]  cmd_q, cmd_d;
  logic        running_q, running_d;
  logic        grav_ovr_q, grav_ovr_d;
  logic [4:0]  pend_q, pend_d;
  logic [23:0] grav_cnt_q, grav_cnt_d;
  logic [3:0]  sync1_q, sync1_d;
  logic [3:0]  sync2_q, sync2_d;
  logic [3:0]  deb_q, deb_d;
  logic [19:0] deb_cnt_q [4];
  logic [19:0] deb_cnt_d [4];
  logic [23:0] rpt_cnt_q [3];
  logic [23:0] rpt_cnt_d [3];

  logic [3:0]  rise;
  logic [2:0]  rpt_hit;
  logic [3:0]  btn_evt;
  logic [23:0] grav_load;
  logic        active;
  logic        grav_exp;
  logic [4:0]  pend_set;
  logic [4:0]  pend_clr;

  assign cmd_if.cmd_valid = cmd_valid_q;
  assign cmd_if.cmd       = cmd_q;
  assign running          = running_q;
  assign grav_ovr         = grav_ovr_q;

  // Button path: 2-FF sync, stability debounce, press edge and L/R/D auto-repeat.
  always_comb begin
    sync1_d = {BtnU, BtnD, BtnR, BtnL};
    sync2_d = sync1_q;
    deb_d   = deb_q;
    for (int i = 0; i < 4; i++) begin
      deb_cnt_d[i] = deb_cnt_q[i];
      if (sync2_q[i] == deb_q[i]) begin
        deb_cnt_d[i] = 20'd0;
      end else if (deb_cnt_q[i] == DEB_LAST) begin
        deb_d[i]     = sync2_q[i];
        deb_cnt_d[i] = 20'd0;
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + 20'd1;
      end
    end
    rise = deb_d & ~deb_q;
    // Repeat counter restarts at the press and is held clear once released.
    for (int i = 0; i < 3; i++) begin
      rpt_hit[i]   = 1'b0;
      rpt_cnt_d[i] = 24'd0;
      if (!rise[i] && deb_d[i]) begin
        if (rpt_cnt_q[i] == RPT_LAST) begin
          rpt_hit[i] = 1'b1;
        end else begin
          rpt_cnt_d[i] = rpt_cnt_q[i] + 24'd1;
        end
      end
    end
    btn_evt = rise | {1'b0, rpt_hit};
  end

  // Scheduler FSM next state, gravity counter and pending-request bookkeeping.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    cmd_valid_d = cmd_valid_q;
    grav_ovr_d  = grav_ovr_q;
    grav_cnt_d  = grav_cnt_q;
    pend_clr    = 5'd0;
    grav_load   = grav_period(level) - 24'd1;
    active      = (state_q == S_RUN) || (state_q == S_ISSUE);
    grav_exp    = active && (grav_cnt_q == 24'd0);

    if (active) begin
      grav_cnt_d = grav_exp ? grav_load : (grav_cnt_q - 24'd1);
    end
    pend_set = active ? {grav_exp, btn_evt} : 5'd0;
    if (grav_exp && pend_q[4]) begin
      grav_ovr_d = 1'b1;
    end

    case (state_q)
      S_IDLE, S_OVER: begin
        cmd_valid_d = 1'b0;
        if (Start) begin
          state_d    = S_RUN;
          grav_cnt_d = grav_load;
          grav_ovr_d = 1'b0;
        end
      end
      S_RUN: begin
        if (game_over) begin
          state_d = S_OVER;
        end else if (|pend_q) begin
          cmd_d       = pick_cmd(pend_q);
          cmd_valid_d = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cmd_if.cmd_ack) begin
          pend_clr[cmd_q] = 1'b1;
          cmd_valid_d     = 1'b0;
          state_d         = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Set wins over a same-cycle clear; nothing stays pending outside play.
    pend_d    = active ? ((pend_q & ~pend_clr) | pend_set) : 5'd0;
    running_d = (state_d == S_RUN) || (state_d == S_ISSUE);
  end

  // State and registered outputs; async reset also drops cmd_valid immediately.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_IDLE;
      cmd_valid_q <= 1'b0;
      cmd_q       <= 3'd0;
      running_q   <= 1'b0;
      grav_ovr_q  <= 1'b0;
      pend_q      <= 5'd0;
      grav_cnt_q  <= 24'd0;
      sync1_q     <= 4'd0;
      sync2_q     <= 4'd0;
      deb_q       <= 4'd0;
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= 20'd0;
      for (int i = 0; i < 3; i++) rpt_cnt_q[i] <= 24'd0;
    end else begin
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
      running_q   <= running_d;
      grav_ovr_q  <= grav_ovr_d;
      pend_q      <= pend_d;
      grav_cnt_q  <= grav_cnt_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_q       <= deb_d;
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= deb_cnt_d[i];
      for (int i = 0; i < 3; i++) rpt_cnt_q[i] <= rpt_cnt_d[i];
    end
  end

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler with small timing parameters.
// A responder acks each command a programmable number of cycles after it
// appears and logs every command with the cycle it was first offered.
module tb_move_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, game_over, btn_l, btn_r, btn_d, btn_u;
  logic [3:0] level;
  logic       running, grav_ovr;

  move_scheduler_if bus ();

  move_scheduler #(
    .TICK_DIV  (24'd100),
    .LVL_STEP  (24'd10),
    .MIN_PERIOD(24'd20),
    .DEB_CYCLES(20'd4),
    .RPT_CYCLES(24'd50)
  ) dut (
    .Clk      (clk),
    .Reset_n  (rst_n),
    .Start    (start),
    .game_over(game_over),
    .BtnL     (btn_l),
    .BtnR     (btn_r),
    .BtnD     (btn_d),
    .BtnU     (btn_u),
    .level    (level),
    .cmd_if   (bus),
    .running  (running),
    .grav_ovr (grav_ovr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         total = 0;
  int         passed = 0;
  int         ack_dly = 1;
  int         wcnt = 0;
  int         unstable = 0;
  logic       vprev = 1'b0;
  logic [2:0] cur_cmd = 3'd0;
  int         log_cyc[$];
  int         log_cmd[$];

  // Responder/monitor: logs each new command, watches cmd stability, acks after ack_dly.
  always @(negedge clk) begin
    if (!rst_n) begin
      bus.cmd_ack = 1'b0;
      vprev       = 1'b0;
      wcnt        = 0;
    end else begin
      if (bus.cmd_ack) begin
        bus.cmd_ack = 1'b0;
      end else if (bus.cmd_valid) begin
        if (!vprev) begin
          log_cyc.push_back(cyc);
          log_cmd.push_back(int'(bus.cmd));
          cur_cmd = bus.cmd;
          wcnt    = 0;
        end else if (bus.cmd !== cur_cmd) begin
          unstable++;
        end
        if (wcnt >= ack_dly) bus.cmd_ack = 1'b1;
        else                 wcnt++;
      end
      vprev = bus.cmd_valid;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act >= lo && act <= hi) passed++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; game_over = 1'b0;
    btn_l = 1'b0; btn_r = 1'b0; btn_d = 1'b0; btn_u = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Returns the cycle count of the clock edge that accepted Start.
  task automatic do_start(output int t0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
  endtask

  function automatic int entry_cmd(input int idx);
    return (idx < log_cmd.size()) ? log_cmd[idx] : -1;
  endfunction

  function automatic int entry_cyc(input int idx);
    return (idx < log_cyc.size()) ? log_cyc[idx] : -100000;
  endfunction

  // Index of the n-th (0-based) logged command equal to c at or after base, or a huge value.
  function automatic int nth_of(input int base, input int c, input int n);
    int k = 0;
    for (int i = base; i < log_cmd.size(); i++) begin
      if (log_cmd[i] == c) begin
        if (k == n) return i;
        k++;
      end
    end
    return 1 << 20;
  endfunction

  function automatic int count_of(input int base, input int c);
    int k = 0;
    for (int i = base; i < log_cmd.size(); i++) if (log_cmd[i] == c) k++;
    return k;
  endfunction

  typedef struct {
    logic [3:0] lvl;
    int         period;
  } grav_vec_t;

  grav_vec_t gv[6];

  initial begin
    int base;
    int base2;
    int t0;
    int n;
    int uns0;

    gv[0] = '{4'd0,  100};
    gv[1] = '{4'd1,  90};
    gv[2] = '{4'd5,  50};
    gv[3] = '{4'd8,  20};
    gv[4] = '{4'd9,  20};
    gv[5] = '{4'd15, 20};

    rst_n = 1'b0; start = 1'b0; game_over = 1'b0; level = 4'd0;
    btn_l = 1'b0; btn_r = 1'b0; btn_d = 1'b0; btn_u = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_cmd_valid", int'(bus.cmd_valid), 0);
    chk("reset_cmd", int'(bus.cmd), 0);
    chk("reset_running", int'(running), 0);
    chk("reset_grav_ovr", int'(grav_ovr), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Gravity period per level, including the floor and a product above TICK_DIV.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      level   = gv[i].lvl;
      ack_dly = 1;
      base    = log_cmd.size();
      do_start(t0);
      repeat (2 * gv[i].period + 10) @(negedge clk);
      chk($sformatf("grav_lvl%0d_count", gv[i].lvl), log_cmd.size() - base, 2);
      chk($sformatf("grav_lvl%0d_cmd", gv[i].lvl), entry_cmd(base), 4);
      chk($sformatf("grav_lvl%0d_period", gv[i].lvl),
          entry_cyc(base + 1) - entry_cyc(base), gv[i].period);
    end

    // Reset while a command is being offered.
    do_reset();
    level   = 4'd0;
    ack_dly = 1000;
    do_start(t0);
    n = 0;
    while (!bus.cmd_valid && n < 150) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_valid_seen", int'(bus.cmd_valid), 1);
    #2 rst_n = 1'b0;
    #1 chk("midrst_async_drop", int'(bus.cmd_valid), 0);
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    ack_dly = 1;
    base    = log_cmd.size();
    repeat (150) @(negedge clk);
    chk("midrst_no_cmd", log_cmd.size() - base, 0);
    chk("midrst_running", int'(running), 0);

    // Short glitch on BtnL is filtered out.
    do_reset();
    do_start(t0);
    repeat (5) @(negedge clk);
    base  = log_cmd.size();
    btn_l = 1'b1;
    repeat (3) @(negedge clk);
    btn_l = 1'b0;
    repeat (40) @(negedge clk);
    chk("glitch_no_cmd", log_cmd.size() - base, 0);

    // BtnL held 200 cycles: one press plus three repeats.
    do_reset();
    base = log_cmd.size();
    do_start(t0);
    btn_l = 1'b1;
    repeat (200) @(negedge clk);
    btn_l = 1'b0;
    repeat (80) @(negedge clk);
    chk("hold_left_count", count_of(base, 0), 4);
    chk_range("hold_left_latency", entry_cyc(nth_of(base, 0, 0)) - t0, 5, 8);
    chk("hold_left_repeat", entry_cyc(nth_of(base, 0, 1)) - entry_cyc(nth_of(base, 0, 0)), 50);

    // BtnU + BtnR land with a gravity expiry; slow ack.
    do_reset();
    ack_dly = 10;
    uns0    = unstable;
    base    = log_cmd.size();
    do_start(t0);
    repeat (94) @(negedge clk);
    btn_u = 1'b1;
    btn_r = 1'b1;
    repeat (12) @(negedge clk);
    btn_u = 1'b0;
    btn_r = 1'b0;
    repeat (60) @(negedge clk);
    chk("prio_count", log_cmd.size() - base, 3);
    chk("prio_first_gravity", entry_cmd(base), 4);
    chk("prio_second_rotate", entry_cmd(base + 1), 3);
    chk("prio_third_right", entry_cmd(base + 2), 1);
    chk_range("prio_held_until_ack", entry_cyc(base + 1) - entry_cyc(base), 12, 16);
    chk("prio_cmd_stable", unstable - uns0, 0);

    // Gravity overrun while the first GRAVITY stays unacked.
    do_reset();
    level   = 4'd0;
    ack_dly = 250;
    base    = log_cmd.size();
    do_start(t0);
    repeat (150) @(negedge clk);
    chk("ovr_not_yet", int'(grav_ovr), 0);
    repeat (240) @(negedge clk);
    ack_dly = 1;
    chk("ovr_set", int'(grav_ovr), 1);
    chk("ovr_no_extra_gravity", log_cmd.size() - base, 1);
    repeat (20) @(negedge clk);
    chk("ovr_next_gravity_on_time", entry_cyc(base + 1) - entry_cyc(base), 300);

    // game_over freezes the scheduler until Start.
    game_over = 1'b1;
    repeat (2) @(negedge clk);
    game_over = 1'b0;
    chk("over_running", int'(running), 0);
    chk("over_cmd_valid", int'(bus.cmd_valid), 0);
    base2 = log_cmd.size();
    repeat (150) @(negedge clk);
    chk("over_no_cmd", log_cmd.size() - base2, 0);
    chk("over_ovr_kept", int'(grav_ovr), 1);
    do_start(t0);
    chk("restart_running", int'(running), 1);
    chk("restart_ovr_clear", int'(grav_ovr), 0);
    repeat (110) @(negedge clk);
    chk("restart_gravity_cmd", entry_cmd(base2), 4);
    chk_range("restart_gravity_delay", entry_cyc(base2) - t0, 99, 103);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
